// File: rtl/bird_if.sv
// bird_if: signal bundle between the game input logic and bird_controller.
//   flap      one-cycle pulse per synchronized button press (to controller)
//   hit       pipe collision level (to controller)
//   bird_row  current bird row, 0 = bottom (from controller)
//   playing   high while the bird is rising or falling (from controller)
//   dead      high while the game is frozen after a crash (from controller)
//   tick      one-cycle movement step pulse (from controller)
// modport master: the side that produces flap/hit and consumes status.
// modport slave : the controller side.
interface bird_if #(
    parameter int ROWS = 8
);
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

    logic          flap;
    logic          hit;
    logic [RW-1:0] bird_row;
    logic          playing;
    logic          dead;
    logic          tick;

    modport master (
        output flap,
        output hit,
        input  bird_row,
        input  playing,
        input  dead,
        input  tick
    );

    modport slave (
        input  flap,
        input  hit,
        output bird_row,
        output playing,
        output dead,
        output tick
    );
endinterface

// File: rtl/bird_controller.sv
// bird_controller: vertical motion and game-state sequencer for the bird.
// A step divider paces movement; each flap grants RISE_STEPS upward steps,
// after which gravity pulls the bird down one row per step. Hitting a pipe,
// or a step taken while already on the bottom row, freezes the game; a flap
// then parks the bird again and the next flap restarts play.
// Ports:
//   clk    system clock
//   reset  synchronous, active-high reset
//   bus    bird_if.slave: flap/hit in; bird_row/playing/dead/tick out
module bird_controller #(
    parameter int ROWS       = 8,
    parameter int START_ROW  = 4,
    parameter int TICK_DIV   = 25_000_000,
    parameter int RISE_STEPS = 2
) (
    input  logic  clk,
    input  logic  reset,
    bird_if.slave bus
);
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int DW = $clog2(TICK_DIV);
    localparam int CW = $clog2(RISE_STEPS + 1);

    localparam logic [RW-1:0] ROW_TOP   = RW'(ROWS - 1);
    localparam logic [RW-1:0] ROW_START = RW'(START_ROW);
    localparam logic [RW-1:0] ROW_BOT   = RW'(0);
    localparam logic [DW-1:0] DIV_LAST  = DW'(TICK_DIV - 1);
    localparam logic [CW-1:0] RISE_LOAD = CW'(RISE_STEPS);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RISE = 2'd1,
        S_FALL = 2'd2,
        S_DEAD = 2'd3
    } state_t;

    state_t        state_r;
    logic [DW-1:0] div_r;
    logic [CW-1:0] rcnt_r;
    logic [RW-1:0] row_r;
    logic          playing_r;
    logic          dead_r;
    logic          tick_r;
    logic          strobe_s;

    // Step strobe: last count of the divider period.
    always_comb begin
        strobe_s = (div_r == DIV_LAST);
    end

    assign bus.bird_row = row_r;
    assign bus.playing  = playing_r;
    assign bus.dead     = dead_r;
    assign bus.tick     = tick_r;

    // Game state machine with divider, rise budget and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= S_IDLE;
            div_r     <= DW'(0);
            rcnt_r    <= CW'(0);
            row_r     <= ROW_START;
            playing_r <= 1'b0;
            dead_r    <= 1'b0;
            tick_r    <= 1'b0;
        end else begin
            tick_r <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (bus.flap) begin
                        state_r   <= S_RISE;
                        rcnt_r    <= RISE_LOAD;
                        div_r     <= DW'(0);
                        playing_r <= 1'b1;
                    end else begin
                        state_r <= S_IDLE;
                    end
                end
                S_RISE, S_FALL: begin
                    // The divider free-runs during play, even across flaps,
                    // so step spacing stays locked to the game start.
                    div_r <= strobe_s ? DW'(0) : div_r + DW'(1);
                    if (bus.hit) begin
                        state_r   <= S_DEAD;
                        playing_r <= 1'b0;
                        dead_r    <= 1'b1;
                    end else if (bus.flap) begin
                        // A flap pre-empts a coincident step: no move, no tick.
                        state_r <= S_RISE;
                        rcnt_r  <= RISE_LOAD;
                    end else if (strobe_s) begin
                        tick_r <= 1'b1;
                        if (state_r == S_RISE) begin
                            // Clamped steps at the top still use up the budget.
                            if (row_r != ROW_TOP) begin
                                row_r <= row_r + RW'(1);
                            end else begin
                                row_r <= row_r;
                            end
                            rcnt_r <= rcnt_r - CW'(1);
                            if (rcnt_r == CW'(1)) begin
                                state_r <= S_FALL;
                            end else begin
                                state_r <= S_RISE;
                            end
                        end else begin
                            if (row_r == ROW_BOT) begin
                                state_r   <= S_DEAD;
                                playing_r <= 1'b0;
                                dead_r    <= 1'b1;
                            end else begin
                                row_r <= row_r - RW'(1);
                            end
                        end
                    end else begin
                        state_r <= state_r;
                    end
                end
                S_DEAD: begin
                    if (bus.flap) begin
                        state_r <= S_IDLE;
                        row_r   <= ROW_START;
                        rcnt_r  <= CW'(0);
                        dead_r  <= 1'b0;
                    end else begin
                        state_r <= S_DEAD;
                    end
                end
                default: begin
                    state_r   <= S_IDLE;
                    row_r     <= ROW_START;
                    rcnt_r    <= CW'(0);
                    playing_r <= 1'b0;
                    dead_r    <= 1'b0;
                end
            endcase
        end
    end
endmodule
